// File: rtl/row_packer.sv
// Packs a serial RGB pixel stream into COL-pixel rows with a double-buffered row handshake.
// Optional end-of-line edge replication: define ROW_PACKER_EOL_PAD_EN to add the pix_eol input.
module row_packer #(
  parameter int COL   = 256,
  parameter int ROW   = 256,
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     SET,
  input  logic [3*WIDTH-1:0]       pix_in,
  input  logic                     pix_valid,
`ifdef ROW_PACKER_EOL_PAD_EN
  input  logic                     pix_eol,
`endif
  output logic                     pix_ready,
  output logic [COL*WIDTH*3-1:0]   row_out,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [$clog2(ROW)-1:0]   row_index,
  output logic                     frame_done
);

  localparam int PW  = 3 * WIDTH;
  localparam int CW  = $clog2(COL);
  localparam int RIW = $clog2(ROW);
  localparam int RCW = RIW + 1;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RCW-1:0]   rowcnt;
  logic [COL*PW-1:0] asm_buf;
  logic [COL*PW-1:0] asm_next;

  logic accept;
  logic handoff;
  logic pad;
  logic row_done;
  logic slot_free;
  logic last_row;

  assign accept    = pix_valid && pix_ready;
  assign handoff   = row_valid && row_ready;
`ifdef ROW_PACKER_EOL_PAD_EN
  assign pad       = pix_eol;
`else
  assign pad       = 1'b0;
`endif
  assign row_done  = (col == CW'(COL - 1)) || pad;
  assign slot_free = !row_valid || row_ready;
  assign last_row  = (rowcnt == RCW'(ROW - 1));

  // asm_next is the assembly row including the pixel accepted this cycle, so a
  // completing row can go straight to row_out without an extra cycle.
  for (genvar gi = 0; gi < COL; gi++) begin : g_slot
    localparam logic [CW-1:0] SLOT = CW'(gi);
    logic wr;
    assign wr = accept && ((SLOT == col) || (pad && (SLOT > col)));
    assign asm_next[gi*PW +: PW] = wr ? pix_in : asm_buf[gi*PW +: PW];
  end

  always_ff @(posedge CLK) begin
    asm_buf <= asm_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pix_ready  <= 1'b0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
      row_out    <= '0;
      row_index  <= '0;
      col        <= '0;
      rowcnt     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (SET) begin
        // Start (or restart) a frame; any partial or pending row is dropped.
        state     <= FILL;
        pix_ready <= 1'b1;
        row_valid <= 1'b0;
        col       <= '0;
        rowcnt    <= '0;
      end else begin
        case (state)
          IDLE: ;
          FILL: begin
            if (accept && row_done) begin
              col <= '0;
              if (slot_free) begin
                row_out   <= asm_next;
                row_valid <= 1'b1;
                row_index <= rowcnt[RIW-1:0];
                rowcnt    <= rowcnt + 1'b1;
                if (last_row) begin
                  state     <= DRAIN;
                  pix_ready <= 1'b0;
                end
              end else begin
                state     <= HOLD;
                pix_ready <= 1'b0;
              end
            end else begin
              if (accept) col <= col + 1'b1;
              if (handoff) row_valid <= 1'b0;
            end
          end
          HOLD: begin
            if (handoff) begin
              row_out   <= asm_buf;
              row_index <= rowcnt[RIW-1:0];
              rowcnt    <= rowcnt + 1'b1;
              if (last_row) begin
                state     <= DRAIN;
                pix_ready <= 1'b0;
              end else begin
                state     <= FILL;
                pix_ready <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (handoff) begin
              frame_done <= 1'b1;
              row_valid  <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            state     <= IDLE;
            pix_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_row_packer.sv
// Directed testbench for row_packer: single rows, backpressure/HOLD, frame abort,
// a full frame, asynchronous reset and (when built with the macro) end-of-line padding.
module tb_row_packer;
  localparam int COL = 256;
  localparam int ROW = 256;
  localparam int W   = 8;
  localparam int PW  = 3 * W;
  localparam int RBW = COL * PW;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           SET = 1'b0;
  logic [PW-1:0]  pix_in = '0;
  logic           pix_valid = 1'b0;
`ifdef ROW_PACKER_EOL_PAD_EN
  logic           pix_eol = 1'b0;
`endif
  logic           pix_ready;
  logic [RBW-1:0] row_out;
  logic           row_valid;
  logic           row_ready = 1'b0;
  logic [7:0]     row_index;
  logic           frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int hc       = 0;
  int fd_cnt   = 0;
  bit mon_en   = 1'b0;
  bit abort    = 1'b0;
  logic [RBW-1:0] exp_row;

  row_packer #(.COL(COL), .ROW(ROW), .WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SET        (SET),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
`ifdef ROW_PACKER_EOL_PAD_EN
    .pix_eol    (pix_eol),
`endif
    .pix_ready  (pix_ready),
    .row_out    (row_out),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_index  (row_index),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [RBW-1:0] obs, input logic [RBW-1:0] exp);
    int bad;
    bad = -1;
    for (int k = COL - 1; k >= 0; k--)
      if (obs[k*PW +: PW] !== exp[k*PW +: PW]) bad = k;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s slot %0d: observed %06h expected %06h", tag, bad,
             obs[bad*PW +: PW], exp[bad*PW +: PW]);
    end
  endtask

  // One clock; row handoffs and frame_done pulses are tallied while mon_en is set.
  task automatic tick();
    if (mon_en && row_valid && row_ready) begin
      chk("handoff_index", 64'(row_index), 64'(hc % ROW));
      hc++;
    end
    @(posedge CLK);
    #1;
    if (mon_en && frame_done) fd_cnt++;
  endtask

  task automatic push(input logic [PW-1:0] p);
    int guard;
    if (abort) return;
    guard = 0;
    pix_in    = p;
    pix_valid = 1'b1;
    while (!pix_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!pix_ready) begin
      n_checks++;
      n_fail++;
      abort = 1'b1;
      $error("FAIL push_timeout: observed pix_ready=0 expected 1 within 50 cycles");
    end else begin
      tick();
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_pix_ready", 64'(pix_ready), 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_row_index", 64'(row_index), 64'd0);
    exp_row = '0;
    chk_row("rst_row_out", row_out, exp_row);
    RST = 1'b0;
    tick();
    chk("idle_pix_ready", 64'(pix_ready), 64'd0);

    // Row 0: {k,k,k}, downstream ready
    SET = 1'b1;
    tick();
    SET = 1'b0;
    chk("set_pix_ready", 64'(pix_ready), 64'd1);
    row_ready = 1'b1;
    for (int k = 0; k < COL - 1; k++) push({8'(k), 8'(k), 8'(k)});
    chk("row0_not_early", 64'(row_valid), 64'd0);
    push({8'd255, 8'd255, 8'd255});
    for (int k = 0; k < COL; k++) exp_row[k*PW +: PW] = {8'(k), 8'(k), 8'(k)};
    chk("row0_valid", 64'(row_valid), 64'd1);
    chk("row0_index", 64'(row_index), 64'd0);
    chk_row("row0_data", row_out, exp_row);

    // Row 1 with downstream stalled: completes into HOLD
    row_ready = 1'b0;
    for (int k = 0; k < COL; k++) push({8'(k), 8'(255 - k), 8'h5A});
    chk("hold_pix_ready", 64'(pix_ready), 64'd0);
    tick();
    tick();
    chk("hold_row_valid", 64'(row_valid), 64'd1);
    chk("hold_row_index", 64'(row_index), 64'd0);
    chk_row("hold_row0_stable", row_out, exp_row);
    row_ready = 1'b1;
    tick();
    for (int k = 0; k < COL; k++) exp_row[k*PW +: PW] = {8'(k), 8'(255 - k), 8'h5A};
    chk("row1_valid", 64'(row_valid), 64'd1);
    chk("row1_index", 64'(row_index), 64'd1);
    chk_row("row1_data", row_out, exp_row);
    chk("row1_pix_ready", 64'(pix_ready), 64'd1);
    tick();
    chk("row1_drained", 64'(row_valid), 64'd0);

    // Row 2, then abort with SET at col 100 of row 3 while row 2 is pending
    for (int k = 0; k < COL; k++) push({8'h22, 8'(k), 8'h11});
    chk("row2_index", 64'(row_index), 64'd2);
    row_ready = 1'b0;
    for (int k = 0; k < 100; k++) push({8'hEE, 8'hEE, 8'(k)});
    chk("pre_abort_valid", 64'(row_valid), 64'd1);
    SET = 1'b1;
    tick();
    SET = 1'b0;
    chk("abort_row_valid", 64'(row_valid), 64'd0);
    chk("abort_pix_ready", 64'(pix_ready), 64'd1);
    chk("abort_no_frame_done", 64'(frame_done), 64'd0);
    row_ready = 1'b1;
    for (int k = 0; k < COL; k++) push({8'hC3, 8'(k), 8'(k)});
    for (int k = 0; k < COL; k++) exp_row[k*PW +: PW] = {8'hC3, 8'(k), 8'(k)};
    chk("post_abort_index", 64'(row_index), 64'd0);
    chk("post_abort_valid", 64'(row_valid), 64'd1);
    chk_row("post_abort_data", row_out, exp_row);

    // Full frame of ROW rows with downstream always ready
    SET = 1'b1;
    tick();
    SET = 1'b0;
    hc = 0;
    fd_cnt = 0;
    mon_en = 1'b1;
    for (int r = 0; r < ROW; r++) begin
      for (int k = 0; k < COL; k++) push({8'(r), 8'(k), 8'h3C});
      chk("frame_row_index", 64'(row_index), 64'(r));
    end
    for (int k = 0; k < COL; k++) exp_row[k*PW +: PW] = {8'd255, 8'(k), 8'h3C};
    chk_row("frame_last_data", row_out, exp_row);
    chk("drain_pix_ready", 64'(pix_ready), 64'd0);
    tick();
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("frame_end_valid", 64'(row_valid), 64'd0);
    tick();
    chk("frame_done_cleared", 64'(frame_done), 64'd0);
    mon_en = 1'b0;
    chk("frame_handoffs", 64'(hc), 64'(ROW));
    chk("frame_done_count", 64'(fd_cnt), 64'd1);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("idle_after_frame", 64'(pix_ready), 64'd0);
    chk("idle_after_frame_valid", 64'(row_valid), 64'd0);

    // Asynchronous reset mid-row with a row pending
    SET = 1'b1;
    tick();
    SET = 1'b0;
    row_ready = 1'b0;
    for (int k = 0; k < COL; k++) push({8'(k), 8'h77, 8'(k)});
    for (int k = 0; k < 50; k++) push({8'h99, 8'(k), 8'h99});
    chk("pre_rst_valid", 64'(row_valid), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_pix_ready", 64'(pix_ready), 64'd0);
    chk("arst_row_valid", 64'(row_valid), 64'd0);
    chk("arst_row_index", 64'(row_index), 64'd0);
    chk("arst_frame_done", 64'(frame_done), 64'd0);
    exp_row = '0;
    chk_row("arst_row_out", row_out, exp_row);
    #2;
    RST = 1'b0;
    row_ready = 1'b1;
    pix_valid = 1'b1;
    tick();
    tick();
    tick();
    pix_valid = 1'b0;
    chk("post_rst_ignored", 64'(pix_ready), 64'd0);
    chk("post_rst_no_row", 64'(row_valid), 64'd0);

`ifdef ROW_PACKER_EOL_PAD_EN
    // End-of-line padding at col 9
    SET = 1'b1;
    tick();
    SET = 1'b0;
    for (int k = 0; k < 9; k++) push({8'(k), 8'(k), 8'(k)});
    pix_eol = 1'b1;
    push(24'hA0B0C0);
    pix_eol = 1'b0;
    for (int k = 0; k < COL; k++)
      exp_row[k*PW +: PW] = (k < 9) ? {8'(k), 8'(k), 8'(k)} : 24'hA0B0C0;
    chk("eol_valid", 64'(row_valid), 64'd1);
    chk("eol_index", 64'(row_index), 64'd0);
    chk_row("eol_data", row_out, exp_row);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/row_packer.md
Name: row_packer

Overview:
- Transmit side of the row interface consumed by the median and Sobel stages.
- Accepts a serial RGB pixel stream over a valid/ready handshake and assembles each row of COL pixels into one wide word.
- Presents each row on a COL*WIDTH*3-bit bus with a row-level valid/ready handshake.
- Double-buffered: the next row fills while the previous row waits downstream. Frame framing is via SET and frame_done.

Parameters:
- COL, 256, pixels per row
- ROW, 256, rows per frame
- WIDTH, 8, bits per colour channel

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  reset, asynchronous, active-high
- SET  input  1  frame start pulse
- pix_in  input  3*WIDTH  pixel data; [3W-1:2W]=R, [2W-1:W]=G, [W-1:0]=B
- pix_valid  input  1  pix_in is valid
- pix_ready  output  1  packer can accept a pixel this cycle
- row_out  output  COL*WIDTH*3  assembled row; pixel k occupies [k*3W +: 3W], pixel 0 is leftmost
- row_valid  output  1  row_out holds a complete row
- row_ready  input  1  downstream accepts row_out
- row_index  output  clog2(ROW)  index of the row currently in row_out
- frame_done  output  1  one-cycle pulse on handoff of the last row of a frame

Behaviour:
- Reset: pix_ready=0, row_valid=0, frame_done=0, row_out=0, row_index=0, state=IDLE, column and row counters cleared.
- Handshakes:
  - A pixel is accepted when pix_valid && pix_ready.
  - A row is handed off when row_valid && row_ready.
  - row_out and row_index stay stable while row_valid=1 and row_ready=0.
- State IDLE:
  - pix_ready=0.
  - SET=1 -> FILL; col=0, rowcnt=0.
- State FILL:
  - pix_ready=1.
  - Each accepted pixel is written to assembly buffer slot col; col increments.
- Last pixel of a row (col==COL-1 accepted):
  - If the output slot is free (row_valid==0, or row_ready==1 this cycle): the assembly row, including this pixel, loads into row_out. row_valid=1 and row_index=rowcnt on the next cycle, i.e. latency 1 cycle. col=0, rowcnt increments, and the block stays in FILL.
  - Otherwise -> HOLD.
- State HOLD:
  - pix_ready=0.
  - When row_ready && row_valid: the held assembly row loads into row_out the same edge, row_valid stays 1, rowcnt increments, -> FILL (or -> DRAIN if this was row ROW-1).
- Frame end: when row ROW-1 has been loaded into row_out -> DRAIN.
- State DRAIN:
  - pix_ready=0.
  - On handoff of row ROW-1: frame_done=1 for exactly one cycle, row_valid=0, -> IDLE.
- Handoff with nothing pending: row_valid drops to 0 on the next cycle.
- Simultaneous handoff and load: when a handoff and a new load occur on the same edge, row_valid stays 1 with the new data. There is no bubble.
- SET outside IDLE: aborts the frame.
  - col=0, rowcnt=0, row_valid=0, partial row discarded, -> FILL.
  - frame_done is not pulsed.
- Counters: col wraps only via the last-pixel rule. rowcnt is clog2(ROW)+1 bits internally; row_index is rowcnt truncated.
- RST mid-operation: immediate return to reset values regardless of state.
- pix_valid while pix_ready=0: ignored. Upstream must hold pix_in.

Optional Feature:
- Macro ROW_PACKER_EOL_PAD_EN.
- Defined:
  - Adds input port pix_eol (1 bit).
  - If pix_eol=1 on an accepted pixel with col<COL-1, all slots col..COL-1 are filled with that pixel (edge replication for border filtering).
  - The row then completes exactly as if pixel COL-1 had been accepted.
  - pix_eol on the pixel at col==COL-1 has no extra effect.
- Undefined: the port is absent, and every row requires exactly COL accepted pixels.

Test Plan:
- Reset, SET, then 256 pixels pix_in={k,k,k} with row_ready=1 -> row_valid high 1 cycle after pixel 255, row_out[k*24+:24]=={k,k,k}, row_index=0.
- row_ready=0 while a second full row is streamed -> pix_ready drops after pixel 255 of row 1 (HOLD). Raise row_ready -> row 0 handed off, row 1 appears in row_out the next cycle, pix_ready returns to 1.
- Full frame of 256 rows with row_ready=1 -> exactly 256 row handoffs, row_index 0..255, frame_done a single pulse on the 256th handoff, state returns to IDLE.
- SET asserted at col=100 of row 3 -> row_valid=0 next cycle, next row emitted has row_index=0 and contains only post-SET pixels.
- RST asserted asynchronously mid-row -> all outputs 0 before the next clock edge; after RST falls, pixels are ignored until SET.
- With ROW_PACKER_EOL_PAD_EN: pix_eol on pixel col=9 carrying 0xA0B0C0 -> row_valid next cycle, slots 9..255 all equal 0xA0B0C0.
